// File: rtl/generic_slave_spi_pkg.sv
// Shared definitions for the generic SPI slave: FSM encoding,
// synchronizer depth and bit-order constants.
`timescale 1ns/1ps
package generic_slave_spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int unsigned SYNC_DEPTH = 2;

    localparam logic MSB_FIRST = 1'b0;
    localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/generic_slave_spi_pin_sync.sv
// spi_pin_sync: multi-flop synchronizer for one asynchronous SPI pin,
// with rise/fall strobes derived from the synchronized level.
`timescale 1ns/1ps
module spi_pin_sync
    import generic_slave_spi_pkg::*;
#(
    parameter logic RESET_LEVEL = 1'b0
)
(
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_DEPTH-1:0] sync_ff;
    logic                  prev;

    // Synchronizer chain plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff <= RESET_LEVEL ? '1 : '0;
            prev    <= RESET_LEVEL;
        end else begin
            sync_ff <= {sync_ff[SYNC_DEPTH-2:0], din};
            prev    <= sync_ff[SYNC_DEPTH-1];
        end
    end

    assign level = sync_ff[SYNC_DEPTH-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/generic_slave_spi.sv
// generic_slave_spi: SPI slave, all four modes, selectable bit order.
// Optional macro SPI_SLAVE_MISO_TRISTATE_EN: MISO is high-Z when idle or
// in reset; otherwise MISO drives 0 there.
`timescale 1ns/1ps
module generic_slave_spi
    import generic_slave_spi_pkg::*;
#(
    parameter int unsigned WordLen = 8
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               CPOL,
    input  logic               CPHA,
    input  logic               Endianess,
    input  logic [WordLen-1:0] SendData,
    input  logic               SCLK,
    input  logic               SS,
    input  logic               MOSI,
    output logic               MISO,
    output logic [WordLen-1:0] ReceivedData,
    output logic               WordFlg,
    output logic               Busy
);

    localparam int unsigned      CW       = $clog2(WordLen);
    localparam logic [CW-1:0]    LAST_BIT = CW'(WordLen - 1);

    state_t state, state_nxt;

    logic sclk_level, sclk_rise, sclk_fall;
    logic ss_level, ss_rise, ss_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_pins;

    logic               cpol_l, cpha_l, endian_l;
    logic [WordLen-1:0] tx_sr, rx_sr;
    logic [WordLen-1:0] tx_shifted, rx_next;
    logic [CW-1:0]      bit_cnt;
    logic               skip_shift;
    logic               leading, trailing, sample_edge, shift_edge;
    logic               tx_bit;

    spi_pin_sync #(.RESET_LEVEL(1'b0)) u_sclk_sync (
        .clk(clk), .reset(reset), .din(SCLK),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_pin_sync #(.RESET_LEVEL(1'b1)) u_ss_sync (
        .clk(clk), .reset(reset), .din(SS),
        .level(ss_level), .rise(ss_rise), .fall(ss_fall)
    );

    spi_pin_sync #(.RESET_LEVEL(1'b0)) u_mosi_sync (
        .clk(clk), .reset(reset), .din(MOSI),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_pins = ^{sclk_level, ss_level, mosi_rise, mosi_fall};

    // Classify synchronized SCLK edges using the latched mode
    always_comb begin
        leading     = cpol_l ? sclk_fall : sclk_rise;
        trailing    = cpol_l ? sclk_rise : sclk_fall;
        sample_edge = cpha_l ? trailing : leading;
        shift_edge  = cpha_l ? leading  : trailing;
        if (endian_l == LSB_FIRST) begin
            rx_next    = {mosi_level, rx_sr[WordLen-1:1]};
            tx_shifted = {1'b0, tx_sr[WordLen-1:1]};
            tx_bit     = tx_sr[0];
        end else begin
            rx_next    = {rx_sr[WordLen-2:0], mosi_level};
            tx_shifted = {tx_sr[WordLen-2:0], 1'b0};
            tx_bit     = tx_sr[WordLen-1];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state: SS framing only
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = ACTIVE;
            ACTIVE:  if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: mode latch, RX/TX shifting, word completion.
    // A reload (word start or word end) leaves the first bit already on MISO,
    // so the next shift edge that would move past it is skipped: after SS
    // for CPHA=1, after every completed word for both phases.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpol_l       <= 1'b0;
            cpha_l       <= 1'b0;
            endian_l     <= MSB_FIRST;
            tx_sr        <= '0;
            rx_sr        <= '0;
            bit_cnt      <= '0;
            skip_shift   <= 1'b0;
            ReceivedData <= '0;
            WordFlg      <= 1'b0;
        end else begin
            WordFlg <= 1'b0;
            if (state == IDLE) begin
                if (ss_fall) begin
                    cpol_l     <= CPOL;
                    cpha_l     <= CPHA;
                    endian_l   <= Endianess;
                    tx_sr      <= SendData;
                    bit_cnt    <= '0;
                    skip_shift <= CPHA;
                end
            end else begin
                if (sample_edge) begin
                    rx_sr <= rx_next;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt      <= '0;
                        ReceivedData <= rx_next;
                        WordFlg      <= 1'b1;
                        tx_sr        <= SendData;
                        skip_shift   <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end else if (shift_edge) begin
                    if (skip_shift) skip_shift <= 1'b0;
                    else            tx_sr      <= tx_shifted;
                end
            end
        end
    end

    assign Busy = (state == ACTIVE);

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign MISO = (state == ACTIVE && !reset) ? tx_bit : 1'bz;
`else
    assign MISO = (state == ACTIVE && !reset) ? tx_bit : 1'b0;
`endif

endmodule

// File: tb/tb_generic_slave_spi.sv
// Scoreboard bench for generic_slave_spi: directed SPI transfers with
// hand-computed words; a monitor pops expected words on each WordFlg.
`timescale 1ns/1ps
module tb_generic_slave_spi;

    localparam int HALF = 50;  // SCLK = clk/10

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    localparam logic IDLE_MISO = 1'bz;
`else
    localparam logic IDLE_MISO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, CPOL, CPHA, Endianess;
    logic [7:0] SendData;
    logic       SCLK, SS, MOSI;
    logic       MISO;
    logic [7:0] ReceivedData;
    logic       WordFlg, Busy;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];

    logic m_cpol, m_cpha, m_lsb;
    logic [7:0] mi;

    generic_slave_spi #(.WordLen(8)) dut (
        .clk(clk), .reset(reset), .CPOL(CPOL), .CPHA(CPHA),
        .Endianess(Endianess), .SendData(SendData), .SCLK(SCLK), .SS(SS),
        .MOSI(MOSI), .MISO(MISO), .ReceivedData(ReceivedData),
        .WordFlg(WordFlg), .Busy(Busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every WordFlg pulse must match the oldest expected word
    always @(posedge clk) begin
        #1;
        if (WordFlg === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL wordflg_unexpected: got ReceivedData %h with no word expected", ReceivedData);
            end else begin
                check("received_word", ReceivedData, exp_q.pop_front());
            end
        end
    end

    // Master: shifts nbits of mo, captures MISO into mi; on bit 7 also
    // checks that the word was reported within 3 clk of the final sample edge
    task automatic spi_bits(input int unsigned nbits, input logic [7:0] mo, output logic [7:0] mo_miso);
        mo_miso = '0;
        for (int unsigned i = 0; i < nbits; i++) begin
            int unsigned idx = m_lsb ? i : 7 - i;
            if (!m_cpha) begin
                MOSI = mo[idx];
                #HALF;
                mo_miso[idx] = MISO;
                SCLK = ~m_cpol;
            end else begin
                SCLK = ~m_cpol;
                MOSI = mo[idx];
                #HALF;
                mo_miso[idx] = MISO;
                SCLK = m_cpol;
            end
            if (i == 7) begin
                repeat (3) @(posedge clk);
                #2;
                check("wordflg_latency", exp_q.size(), 0);
                #23;
            end else begin
                #HALF;
            end
            if (!m_cpha) SCLK = m_cpol;
        end
    endtask

    task automatic xfer(input string name, input logic [7:0] mo, input logic [7:0] exp_miso);
        logic [7:0] got;
        exp_q.push_back(mo);
        spi_bits(8, mo, got);
        check(name, got, exp_miso);
    endtask

    task automatic set_mode(input logic cpol, input logic cpha, input logic lsb);
        m_cpol = cpol; m_cpha = cpha; m_lsb = lsb;
        CPOL = cpol; CPHA = cpha; Endianess = lsb;
        SCLK = cpol;
        #100;
    endtask

    task automatic ss_start();
        SS = 1'b0;
        #80;
        check("busy_active", Busy, 1'b1);
    endtask

    task automatic ss_end();
        #HALF;
        SS = 1'b1;
        #100;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        CPOL = 1'b0; CPHA = 1'b0; Endianess = 1'b0; SendData = '0;
        m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0;
        repeat (3) @(posedge clk);
        #5;
        check("reset_rx", ReceivedData, 8'h00);
        check("reset_wordflg", WordFlg, 1'b0);
        check("reset_busy", Busy, 1'b0);
        check("reset_miso", MISO, IDLE_MISO);
        reset = 1'b0;
        #100;
        check("idle_miso", MISO, IDLE_MISO);

        // Mode 0, MSB first
        set_mode(1'b0, 1'b0, 1'b0);
        SendData = 8'h3C;
        ss_start();
        xfer("mode0_miso", 8'hA5, 8'h3C);
        ss_end();
        check("idle_busy", Busy, 1'b0);

        // Mode 3, LSB first; config inputs changed mid-transfer must be ignored
        set_mode(1'b1, 1'b1, 1'b1);
        SendData = 8'h0F;
        ss_start();
        CPOL = 1'b0; CPHA = 1'b0; Endianess = 1'b0;
        xfer("mode3_miso", 8'h81, 8'h0F);
        ss_end();

        // Back-to-back words; SendData changed after the first load
        set_mode(1'b0, 1'b0, 1'b0);
        SendData = 8'hC3;
        ss_start();
        SendData = 8'h55;
        xfer("b2b_miso_w1", 8'h12, 8'hC3);
        xfer("b2b_miso_w2", 8'h34, 8'h55);
        ss_end();

        // SS released after 5 bits: partial word discarded
        SendData = 8'hAA;
        ss_start();
        spi_bits(5, 8'hFF, mi);
        SS = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_fall", Busy, 1'b0);
        #4;
        #100;
        check("abort_rx_kept", ReceivedData, 8'h34);

        // Reset at bit 4, then a full transfer
        SendData = 8'h00;
        ss_start();
        spi_bits(4, 8'hFF, mi);
        reset = 1'b1;
        #30;
        check("midreset_rx", ReceivedData, 8'h00);
        check("midreset_wordflg", WordFlg, 1'b0);
        check("midreset_busy", Busy, 1'b0);
        check("midreset_miso", MISO, IDLE_MISO);
        SS = 1'b1;
        #30;
        reset = 1'b0;
        #100;
        check("postreset_rx", ReceivedData, 8'h00);
        SendData = 8'h96;
        ss_start();
        xfer("postreset_miso", 8'h5A, 8'h96);
        ss_end();
        check("final_rx", ReceivedData, 8'h5A);
        check("final_idle_miso", MISO, IDLE_MISO);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/generic_slave_spi.md
GENERIC_SLAVE_SPI -- requirements
Module: generic_slave_spi

Interface
REQ-001 The block SHALL have a parameter WordLen, default 8, setting bits per SPI word (legal range 4..32).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-003 clk  input  1  system clock; every register SHALL be clocked on its rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 CPOL  input  1  SCLK idle level.
REQ-006 CPHA  input  1  0 = sample on leading edge; 1 = sample on trailing edge.
REQ-007 Endianess  input  1  0 = MSB first; 1 = LSB first (both directions).
REQ-008 SendData  input  WordLen  word to shift out on MISO.
REQ-009 SCLK, SS, MOSI  input  1 each  SPI pins from the master; SS is active-low; all are asynchronous to clk.
REQ-010 MISO  output  1  serial data to the master.
REQ-011 ReceivedData  output  WordLen  last complete word received on MOSI.
REQ-012 WordFlg  output  1  one-clk pulse when ReceivedData updates.
REQ-013 Busy  output  1  high while a transfer is active.

Function
REQ-014 SCLK, SS and MOSI SHALL each pass a 2-flop synchronizer; edges SHALL be detected on the synchronized SCLK only.
REQ-015 The leading edge SHALL be the transition away from CPOL; the trailing edge SHALL be the return to CPOL.
REQ-016 The FSM SHALL have two states: IDLE (SS high) and ACTIVE; IDLE->ACTIVE on synchronized SS falling; ACTIVE->IDLE on synchronized SS rising.
REQ-017 On IDLE->ACTIVE, CPOL, CPHA and Endianess SHALL be latched; later changes SHALL be ignored until the next SS assertion.
REQ-018 On IDLE->ACTIVE, SendData SHALL be loaded into the TX shift register and the bit counter cleared.
REQ-019 With CPHA=0, MISO SHALL present the first bit in the cycle after SS is detected; subsequent bits SHALL change on each trailing edge.
REQ-020 With CPHA=1, MISO SHALL change on each leading edge, starting with the first bit.
REQ-021 MOSI SHALL be sampled on each sample edge into the RX shift register in the latched bit order.
REQ-022 After WordLen sample edges: ReceivedData SHALL update, WordFlg SHALL pulse for exactly 1 clk, the counter SHALL wrap to 0, and SendData SHALL be reloaded for back-to-back words while SS stays low.
REQ-023 WordFlg SHALL assert within 3 clk cycles of the final sample edge at the pin.
REQ-024 Correct operation SHALL require an SCLK high and low time of at least 4 clk cycles each.
REQ-025 If SS deasserts mid-word, the partial word SHALL be discarded, WordFlg SHALL stay low, ReceivedData SHALL be unchanged, and the FSM SHALL go to IDLE.
REQ-026 If the SS rising edge and the final sample edge are detected in the same clk, the word SHALL complete (WordFlg=1) before IDLE is entered.
REQ-027 Busy SHALL be 1 exactly while the FSM is in ACTIVE.

Reset
REQ-028 reset SHALL force, on the next clk edge: state IDLE, counter 0, shift registers 0, ReceivedData=0, WordFlg=0, Busy=0, MISO per REQ-030/031, and synchronizer flops to idle (SS=1, SCLK=0, MOSI=0).
REQ-029 reset asserted mid-transfer SHALL abort the transfer without a WordFlg pulse.

Configuration
REQ-030 With macro SPI_SLAVE_MISO_TRISTATE_EN defined, MISO SHALL be high-Z whenever the FSM is in IDLE or reset is asserted.
REQ-031 Without SPI_SLAVE_MISO_TRISTATE_EN, MISO SHALL drive 0 in IDLE and during reset.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (IDLE, ACTIVE), the synchronizer depth constant (2), and the bit-order constants (MSB_FIRST=0, LSB_FIRST=1).
REQ-033 The synchronizer-plus-edge-detector SHALL be one sub-module, spi_pin_sync, instantiated once per input pin and providing level, rise and fall outputs.

Verification
REQ-034 Mode 0 (CPOL=0, CPHA=0), MSB first, SCLK = clk/10: master sends 0xA5 while SendData=0x3C -> ReceivedData=0xA5 with one WordFlg pulse; MISO bit stream 0,0,1,1,1,1,0,0.
REQ-035 Mode 3, Endianess=1: master sends 0x81 with SendData=0x0F -> ReceivedData=0x81; MISO order 1,1,1,1,0,0,0,0.
REQ-036 SS held low for 2 words (0x12, 0x34), with SendData changed to 0x55 between words -> two WordFlg pulses; second MISO word = 0x55.
REQ-037 SS released after 5 bits of 0xFF -> no WordFlg, ReceivedData unchanged, Busy falls within 3 clk cycles.
REQ-038 reset pulsed at bit 4, then a full transfer of 0x5A -> ReceivedData=0x5A; all outputs at reset values during reset.
REQ-039 Run the bench with and without SPI_SLAVE_MISO_TRISTATE_EN -> in IDLE, MISO reads z and 0 respectively.
